// File: rtl/ab_mutex_arbiter.sv
// Two-requester mutual-exclusion arbiter with round-robin tie break,
// a bounded hold time, a forced dead cycle between grants and a saturating grant counter.
module ab_mutex_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             rel,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             timeout,
    output logic [CNT_W-1:0] grant_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2,
        GAP   = 2'd3
    } state_e;

    localparam int unsigned      HOLD_W   = 8;
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_SAT  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                last_b_q, last_b_d;
    logic                a_q, a_d;
    logic                b_q, b_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    grant_cnt_q, grant_cnt_d;
    logic                grant_start;

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        last_b_d    = last_b_q;
        timeout_d   = 1'b0;
        grant_cnt_d = grant_cnt_q;
        grant_start = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A wins a tie only when B held the resource last.
                if (req_a && (!req_b || last_b_q)) begin
                    state_d     = GNT_A;
                    last_b_d    = 1'b0;
                    grant_start = 1'b1;
                end else if (req_b) begin
                    state_d     = GNT_B;
                    last_b_d    = 1'b1;
                    grant_start = 1'b1;
                end
            end
            GNT_A, GNT_B: begin
                if (rel) begin
                    state_d = GAP;
                    hold_d  = '0;
                end else if (hold_q == HOLD_LIM) begin
                    state_d   = GAP;
                    hold_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase

        if (grant_start) begin
            hold_d = HOLD_ONE;
            if (grant_cnt_q != CNT_SAT) begin
                grant_cnt_d = grant_cnt_q + CNT_ONE;
            end
        end

        // Grant outputs are decoded from the next state so they come straight off flops.
        a_d = (state_d == GNT_A);
        b_d = (state_d == GNT_B);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            last_b_q    <= 1'b1;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            timeout_q   <= 1'b0;
            grant_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            last_b_q    <= last_b_d;
            a_q         <= a_d;
            b_q         <= b_d;
            timeout_q   <= timeout_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = a_q | b_q;
    assign timeout   = timeout_q;
    assign grant_cnt = grant_cnt_q;

endmodule
